// File: rtl/spi_echo_pkg.sv
// Shared constants for the SPI echo slave: word size, synchroniser depth,
// bit-counter width and the idle levels the synchronisers reset to.
package spi_echo_pkg;

    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned SYNC_STAGES = 2;

    // Counter must be able to hold the value DATA_WIDTH itself
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    localparam logic CS_N_IDLE = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_echo_sync.sv
// N-stage flop synchroniser for an asynchronous single-bit input,
// with a selectable reset level so the line resets to its idle state.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_echo_top.sv
// SPI mode 0 slave that echoes the last complete received word on MISO
// during the following transaction; all logic runs on the system clock.
module spi_echo_top
    import spi_echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = spi_echo_pkg::DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = spi_echo_pkg::SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
);

    localparam int unsigned BIT_CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic cs_n_s;
    logic sclk_s;
    logic mosi_s;
    logic sclk_q;
    logic sclk_rise;

    logic [DATA_WIDTH-1:0] echo_reg;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    // Equal-depth synchronisers keep MOSI aligned with the SCLK edge it belongs to
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (CS_n),
        .q   (cs_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (SCLK),
        .q   (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (MOSI),
        .q   (mosi_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q <= SCLK_IDLE;
        end else begin
            sclk_q <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    // Shift/echo datapath; a partial word is simply dropped when CS_n rises
    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_reg <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_n_s) begin
                tx_shift <= echo_reg;
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (sclk_rise) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    echo_reg <= rx_next;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    tx_shift <= rx_next;
                    bit_cnt  <= '0;
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    assign MISO = tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_echo_top.sv
// Bench for spi_echo_top: directed plan plus random traffic, compared
// against a model that only remembers the last complete byte.
module tb_spi_echo_top;

    localparam int HALF = 4;

    logic       clk;
    logic       rst;
    logic       CS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rx_data;
    logic       rx_valid;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    logic [7:0] model_echo;
    logic [7:0] txq[$];

    spi_echo_top dut (
        .clk      (clk),
        .rst      (rst),
        .CS_n     (CS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid === 1'b1) vcount++;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SPI word, MSB first; MISO is sampled just before each rising SCLK
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = d[i];
            wait_clks(HALF);
            got[i] = MISO;
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
    endtask

    // Full transaction over every byte in txq, compared with the model
    task automatic xact(input string tag);
        logic [7:0] got;
        int v0;
        v0 = vcount;
        CS_n = 1'b0;
        wait_clks(5);
        foreach (txq[k]) begin
            spi_bits(txq[k], 8, got);
            check({tag, "_miso"}, 32'(got), 32'(model_echo));
            model_echo = txq[k];
        end
        wait_clks(HALF);
        CS_n = 1'b1;
        wait_clks(6);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(model_echo));
        check({tag, "_pulses"}, 32'(vcount - v0), 32'(txq.size()));
    endtask

    task automatic send1(input logic [7:0] b, input string tag);
        txq = {};
        txq.push_back(b);
        xact(tag);
    endtask

    task automatic partial(input logic [7:0] b, input int nbits, input string tag);
        logic [7:0] got;
        int v0;
        v0 = vcount;
        CS_n = 1'b0;
        wait_clks(5);
        spi_bits(b, nbits, got);
        wait_clks(HALF);
        CS_n = 1'b1;
        wait_clks(6);
        check({tag, "_pulses"}, 32'(vcount - v0), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(model_echo));
    endtask

    initial begin
        logic [7:0] got;
        int v0;
        int mode;
        rst = 1'b0;
        CS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        model_echo = 8'h00;
        wait_clks(4);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
        rst = 1'b1;
        wait_clks(4);

        send1(8'hA5, "first");
        send1(8'h5A, "t5a");
        send1(8'hFF, "tff");
        send1(8'h01, "t01");
        send1(8'h00, "t00");

        txq = {};
        txq.push_back(8'h3C);
        txq.push_back(8'hC3);
        xact("burst");

        partial(8'h96, 4, "partial");
        send1(8'h77, "after_partial");

        // SCLK toggling with CS_n high must be ignored
        v0 = vcount;
        for (int i = 0; i < 6; i++) begin
            MOSI = i[0];
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
            wait_clks(HALF);
        end
        check("cs_high_pulses", 32'(vcount - v0), 32'd0);
        check("cs_high_miso", 32'(MISO), 32'(model_echo[7]));
        send1(8'h12, "after_cs_high");

        // Reset in the middle of a byte
        CS_n = 1'b0;
        wait_clks(5);
        spi_bits(8'hE7, 4, got);
        rst = 1'b0;
        wait_clks(3);
        CS_n = 1'b1;
        wait_clks(1);
        model_echo = 8'h00;
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_miso", 32'(MISO), 32'h0);
        rst = 1'b1;
        wait_clks(6);
        send1(8'h99, "post_rst");
        send1(8'h42, "post_rst2");

        // Random traffic: partial words and bursts of one to three bytes
        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                partial(8'($urandom), int'($urandom_range(1, 7)), "rnd_partial");
            end else begin
                txq = {};
                for (int k = 0; k < mode; k++) txq.push_back(8'($urandom));
                xact("rnd_burst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
